// File: rtl/filter_buffer_pkg.sv
// rtl/filter_buffer_pkg.sv - default geometry for the filter-stage candidate FIFO
package filter_buffer_pkg;

    localparam int FB_DATA_WIDTH = 32;
    localparam int FB_DEPTH      = 32;
    localparam int FB_ADDR_WIDTH = 5;

endpackage

// File: rtl/filter_buffer_ram.sv
// rtl/filter_buffer_ram.sv - simple dual-port RAM with registered read port
module filter_buffer_ram
    import filter_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = FB_DATA_WIDTH,
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/filter_buffer.sv
// rtl/filter_buffer.sv - synchronous FIFO between neighbour filter and force arbiter
module filter_buffer
    import filter_buffer_pkg::*;
#(
    parameter int DATA_WIDTH               = FB_DATA_WIDTH,
    parameter int FILTER_BUFFER_DEPTH      = FB_DEPTH,
    parameter int FILTER_BUFFER_ADDR_WIDTH = FB_ADDR_WIDTH
) (
    input  logic                                clock,
    input  logic                                rst_n,
    input  logic [DATA_WIDTH-1:0]               data,
    input  logic                                wrreq,
    input  logic                                rdreq,
    output logic [DATA_WIDTH-1:0]               q,
    output logic                                empty,
    output logic                                full,
    output logic [FILTER_BUFFER_ADDR_WIDTH-1:0] usedw
);

    localparam int AW = FILTER_BUFFER_ADDR_WIDTH;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FILTER_BUFFER_DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_empty;
    logic          r_full;

    logic          w_wr_ok;
    logic          w_rd_ok;
    logic [AW:0]   w_count_nxt;

    // Read and write addresses only coincide when empty or full, so the
    // gating below keeps the RAM free of read-during-write collisions.
    assign w_wr_ok = wrreq & ~r_full;
    assign w_rd_ok = rdreq & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == DEPTH_C);
        end
    end

    filter_buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clock     (clock),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data),
        .i_rd_en   (w_rd_ok),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (q)
    );

    assign empty = r_empty;
    assign full  = r_full;
    assign usedw = r_count[AW-1:0];

endmodule

// File: tb/tb_filter_buffer.sv
// tb/tb_filter_buffer.sv - scoreboard bench for filter_buffer
module tb_filter_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] data  = '0;
    logic          wrreq = 1'b0;
    logic          rdreq = 1'b0;
    logic [DW-1:0] q;
    logic          empty;
    logic          full;
    logic [AW-1:0] usedw;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    logic          exp_rd = 1'b0;

    filter_buffer #(
        .DATA_WIDTH               (DW),
        .FILTER_BUFFER_DEPTH      (DEPTH),
        .FILTER_BUFFER_ADDR_WIDTH (AW)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .data  (data),
        .wrreq (wrreq),
        .rdreq (rdreq),
        .q     (q),
        .empty (empty),
        .full  (full),
        .usedw (usedw)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
        check({tag, "_full"},  32'(full),  32'(mq.size() == DEPTH));
        check({tag, "_usedw"}, 32'(usedw), 32'(mq.size() % DEPTH));
    endtask

    // One clock of stimulus; the reference model decides acceptance.
    task automatic drive(input logic w, input logic [DW-1:0] d, input logic r);
        logic wr_ok;
        logic rd_ok;
        @(negedge clock);
        #1;
        wr_ok = w && (mq.size() < DEPTH);
        rd_ok = r && (mq.size() > 0);
        if (rd_ok) exp_q.push_back(mq.pop_front());
        if (wr_ok) mq.push_back(d);
        wrreq  = w;
        data   = d;
        rdreq  = r;
        exp_rd = rd_ok;
        @(posedge clock);
        #1;
        wrreq  = 1'b0;
        rdreq  = 1'b0;
        exp_rd = 1'b0;
        check_flags("step");
    endtask

    // Monitor: q must show the popped word after an accepted read, else hold.
    initial begin
        logic          v;
        logic [DW-1:0] last_q;
        last_q = '0;
        forever begin
            @(posedge clock);
            v = exp_rd;
            @(negedge clock);
            if (!rst_n) begin
                last_q = '0;
            end else if (v) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL q_read actual=%0h required=none_pending", q);
                end else begin
                    last_q = exp_q.pop_front();
                    check("q_read", q, last_q);
                end
            end else begin
                check("q_hold", q, last_q);
            end
        end
    end

    initial begin
        int wrote;
        int iter;
        logic w;
        logic r;
        logic acc;

        rst_n = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("rst_empty", 32'(empty), 1);
        check("rst_full",  32'(full),  0);
        check("rst_usedw", 32'(usedw), 0);
        check("rst_q",     q,          0);
        @(negedge clock);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) drive(1'b1, DW'(i), 1'b0);
        check("wr6_usedw", 32'(usedw), 6);

        for (int i = 0; i < 5; i++) drive(1'b1, DW'(6 + i), 1'b1);
        check("simul_usedw", 32'(usedw), 6);

        for (int i = 0; i < 6; i++) begin
            drive(1'b0, '0, 1'b1);
            drive(1'b0, '0, 1'b0);
        end
        check("drain_empty", 32'(empty), 1);
        drive(1'b0, '0, 1'b1);
        check("underflow_q",     q,          10);
        check("underflow_usedw", 32'(usedw), 0);

        drive(1'b1, 32'h0000_abcd, 1'b1);
        check("uf_write_usedw", 32'(usedw), 1);
        drive(1'b0, '0, 1'b1);

        for (int i = 0; i < DEPTH; i++) drive(1'b1, DW'(100 + i), 1'b0);
        check("fill_full",  32'(full),  1);
        check("fill_usedw", 32'(usedw), 0);
        drive(1'b1, 32'd999, 1'b1);
        check("ovf_usedw", 32'(usedw), 31);
        check("ovf_full",  32'(full),  0);
        for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, '0, 1'b1);
        check("ovf_drained", 32'(empty), 1);

        wrote = 0;
        iter  = 0;
        while ((wrote < 3 * DEPTH || mq.size() > 0) && iter < 3000) begin
            w   = (wrote < 3 * DEPTH) && ($urandom_range(0, 2) != 0);
            r   = 1'($urandom_range(0, 1));
            acc = w && (mq.size() < DEPTH);
            drive(w, DW'(32'h1000 + wrote), r);
            if (acc) wrote++;
            iter++;
        end
        check("wrap_written", wrote, 3 * DEPTH);
        check("wrap_empty", 32'(empty), 1);

        for (int i = 0; i < 3; i++) drive(1'b1, DW'(50 + i), 1'b0);
        drive(1'b0, '0, 1'b1);
        drive(1'b1, DW'(60), 1'b0);
        @(negedge clock);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_empty", 32'(empty), 1);
        check("arst_full",  32'(full),  0);
        check("arst_usedw", 32'(usedw), 0);
        check("arst_q",     q,          0);
        mq.delete();
        @(negedge clock);
        #1;
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b1);
        drive(1'b1, DW'(7), 1'b0);
        drive(1'b0, '0, 1'b1);

        repeat (2) @(negedge clock);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
